flash_update_sequencer: RTL and testbench

// Sequences one image-update pass on the on-chip flash through the CSR/data command interface of FlashControl.
// Per command: read control reg (CR), unprotect the target sector, erase it, then program NUM words from a

---
 rtl/flash_update_sequencer_pkg.sv | 52 +++++
 rtl/flash_update_sequencer_status_poller.sv | 58 +++++
 rtl/flash_update_sequencer.sv | 172 +++++++++++++++++
 tb/tb_flash_update_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_update_sequencer_pkg.sv
// Shared constants for the flash update sequencer: FSM encodings, CR/SR field
// positions, error codes and the CR rewrite helpers used by the top.
package flash_seq_pkg;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_RD_CR     = 4'd1;
    localparam logic [3:0] S_WR_UNPROT = 4'd2;
    localparam logic [3:0] S_WR_ERASE  = 4'd3;
    localparam logic [3:0] S_POLL_E    = 4'd4;
    localparam logic [3:0] S_CHK_E     = 4'd5;
    localparam logic [3:0] S_WAIT_SRC  = 4'd6;
    localparam logic [3:0] S_WR_DATA   = 4'd7;
    localparam logic [3:0] S_POLL_W    = 4'd8;
    localparam logic [3:0] S_CHK_W     = 4'd9;
    localparam logic [3:0] S_WR_PROT   = 4'd10;
    localparam logic [3:0] S_DONE      = 4'd11;

    localparam int CR_SEC_LSB  = 20;
    localparam int CR_SEC_MSB  = 22;
    localparam int CR_WP_BASE  = 22;    // WP bit for sector s is CR_WP_BASE + s
    localparam int SR_WRITE_OK = 3;
    localparam int SR_ERASE_OK = 4;

    localparam logic [2:0] CR_NONE_SECTOR = 3'd7;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_SECTOR  = 3'd1,
        ERR_ERASE   = 3'd2,
        ERR_WRITE   = 3'd3,
        ERR_TIMEOUT = 3'd4
    } err_code_e;

    // Saved CR with the target sector unprotected and no erase selected.
    function automatic logic [31:0] cr_unprot(input logic [31:0] cr, input logic [2:0] sector);
        logic [31:0] r;
        r = cr;
        r[CR_WP_BASE + int'(sector)] = 1'b0;
        r[CR_SEC_MSB:CR_SEC_LSB] = CR_NONE_SECTOR;
        r[19:0] = '1;
        return r;
    endfunction

    // Same as the unprotect value but with the sector-erase field armed.
    function automatic logic [31:0] cr_erase(input logic [31:0] cr, input logic [2:0] sector);
        logic [31:0] r;
        r = cr_unprot(cr, sector);
        r[CR_SEC_MSB:CR_SEC_LSB] = sector;
        return r;
    endfunction

endpackage

// File: rtl/flash_update_sequencer_status_poller.sv
// Status-register poller: repeats rdsr until the busy field clears or the
// read budget is exhausted, then reports the erase/write success flags.
module flash_status_poller
    import flash_seq_pkg::*;
#(
    parameter int POLL_LIMIT = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       done_csr,
    input  logic [3:0] sr_in,       // {erase_ok, write_ok, busy[1:0]}
    output logic       start_rdsr,
    output logic       done,
    output logic       timeout,
    output logic [1:0] sr_ok        // {erase_ok, write_ok} of the final read
);

    localparam int PW = $clog2(POLL_LIMIT + 1);

    logic          active;
    logic [PW-1:0] remaining;

    // Down-counts remaining SR reads; the read that lands on a count of one is the last allowed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active     <= 1'b0;
            remaining  <= '0;
            start_rdsr <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            sr_ok      <= 2'b00;
        end else begin
            start_rdsr <= 1'b0;
            done       <= 1'b0;
            if (go) begin
                active     <= 1'b1;
                remaining  <= PW'(POLL_LIMIT);
                timeout    <= 1'b0;
                start_rdsr <= 1'b1;
            end else if (active && done_csr) begin
                sr_ok <= sr_in[3:2];
                if (sr_in[1:0] == 2'b00) begin
                    active <= 1'b0;
                    done   <= 1'b1;
                end else if (remaining == PW'(1)) begin
                    active  <= 1'b0;
                    done    <= 1'b1;
                    timeout <= 1'b1;
                end else begin
                    remaining  <= remaining - PW'(1);
                    start_rdsr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/flash_update_sequencer.sv
// Image-update sequencer: read CR, unprotect and erase one sector, program a
// word stream, then restore the saved CR. One FlashControl command at a time.
//
// state       | meaning
// IDLE        | waiting for a command
// RD_CR       | reading CR to save protection
// WR_UNPROT   | clearing WP bit of target sector
// WR_ERASE    | arming sector erase
// POLL_E      | polling SR until erase finishes
// CHK_E       | checking erase success flag
// WAIT_SRC    | waiting for next program word
// WR_DATA     | programming one word
// POLL_W      | polling SR until write finishes
// CHK_W       | checking write success, advancing index
// WR_PROT     | restoring saved CR
// DONE        | one-cycle completion pulse
module flash_update_sequencer
    import flash_seq_pkg::*;
#(
    parameter int ADDR_W     = 17,
    parameter int CNT_W      = 17,
    parameter int POLL_LIMIT = 2000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_sector,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [CNT_W-1:0]  cmd_num,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [31:0]       src_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        err_code,
    output logic              start_rdsr,
    output logic              start_rdcr,
    output logic              start_wrcr,
    output logic [31:0]       wr_data_csr,
    input  logic [31:0]       rd_data_csr,
    input  logic              done_csr,
    output logic              start_wrdata,
    output logic [23:0]       rw_addr_data,
    output logic [31:0]       wr_data_data,
    input  logic              done_data
);

    logic [3:0]        state, state_d;
    logic              ready_q, cmd_sent, issue, poll_go;
    logic              poll_done, poll_timeout;
    logic [1:0]        poll_ok;
    logic [2:0]        sector_q;
    logic [ADDR_W-1:0] base_q, addr_next;
    logic [CNT_W-1:0]  num_q, idx_q, idx_inc;
    logic [31:0]       cr_q, word_q, cr_mux;
    err_code_e         err_q;

    flash_status_poller #(.POLL_LIMIT(POLL_LIMIT)) u_poller (
        .clk        (clk),
        .reset      (reset),
        .go         (poll_go),
        .done_csr   (done_csr),
        .sr_in      ({rd_data_csr[SR_ERASE_OK], rd_data_csr[SR_WRITE_OK], rd_data_csr[1:0]}),
        .start_rdsr (start_rdsr),
        .done       (poll_done),
        .timeout    (poll_timeout),
        .sr_ok      (poll_ok)
    );

    assign cmd_ready = ready_q && (state == S_IDLE);
    assign src_ready = (state == S_WAIT_SRC) && src_valid;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = done && (err_q != ERR_NONE);
    assign err_code  = done ? err_q : ERR_NONE;
    assign issue     = !cmd_sent && (state inside {S_RD_CR, S_WR_UNPROT, S_WR_ERASE, S_POLL_E,
                                                   S_WR_DATA, S_POLL_W, S_WR_PROT});
    assign poll_go   = issue && (state inside {S_POLL_E, S_POLL_W});
    assign idx_inc   = idx_q + CNT_W'(1);
    assign addr_next = base_q + ADDR_W'(idx_q);

    // CR value for the write issued in the current state.
    always_comb begin
        cr_mux = cr_q;
        case (state)
            S_WR_UNPROT: cr_mux = cr_unprot(cr_q, sector_q);
            S_WR_ERASE:  cr_mux = cr_erase(cr_q, sector_q);
            default:     cr_mux = cr_q;
        endcase
    end

    // Next-state logic; command states advance only on the done pulse of their own command.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:      if (cmd_valid && cmd_ready)
                             state_d = (cmd_sector inside {[3'd1:3'd5]}) ? S_RD_CR : S_DONE;
            S_RD_CR:     if (cmd_sent && done_csr) state_d = S_WR_UNPROT;
            S_WR_UNPROT: if (cmd_sent && done_csr) state_d = S_WR_ERASE;
            S_WR_ERASE:  if (cmd_sent && done_csr) state_d = S_POLL_E;
            S_POLL_E:    if (poll_done) state_d = poll_timeout ? S_WR_PROT : S_CHK_E;
            S_CHK_E:     state_d = (!poll_ok[1] || num_q == '0) ? S_WR_PROT : S_WAIT_SRC;
            S_WAIT_SRC:  if (src_valid) state_d = S_WR_DATA;
            S_WR_DATA:   if (cmd_sent && done_data) state_d = S_POLL_W;
            S_POLL_W:    if (poll_done) state_d = poll_timeout ? S_WR_PROT : S_CHK_W;
            S_CHK_W:     state_d = (!poll_ok[0] || idx_inc == num_q) ? S_WR_PROT : S_WAIT_SRC;
            S_WR_PROT:   if (cmd_sent && done_csr) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // State register, command bookkeeping, datapath registers and registered start pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            ready_q      <= 1'b0;
            cmd_sent     <= 1'b0;
            sector_q     <= '0;
            base_q       <= '0;
            num_q        <= '0;
            idx_q        <= '0;
            cr_q         <= '0;
            word_q       <= '0;
            err_q        <= ERR_NONE;
            start_rdcr   <= 1'b0;
            start_wrcr   <= 1'b0;
            start_wrdata <= 1'b0;
            wr_data_csr  <= '0;
            rw_addr_data <= '0;
            wr_data_data <= '0;
        end else begin
            state        <= state_d;
            ready_q      <= 1'b1;
            cmd_sent     <= (state_d != state) ? 1'b0 : (cmd_sent || issue);
            start_rdcr   <= issue && (state == S_RD_CR);
            start_wrcr   <= issue && (state inside {S_WR_UNPROT, S_WR_ERASE, S_WR_PROT});
            start_wrdata <= issue && (state == S_WR_DATA);
            if (issue && (state inside {S_WR_UNPROT, S_WR_ERASE, S_WR_PROT}))
                wr_data_csr <= cr_mux;
            if (issue && (state == S_WR_DATA)) begin
                rw_addr_data <= 24'(addr_next);
                wr_data_data <= word_q;
            end
            case (state)
                S_IDLE: if (cmd_valid && cmd_ready) begin
                    sector_q <= cmd_sector;
                    base_q   <= cmd_base;
                    num_q    <= cmd_num;
                    idx_q    <= '0;
                    err_q    <= (cmd_sector inside {[3'd1:3'd5]}) ? ERR_NONE : ERR_SECTOR;
                end
                S_RD_CR: if (cmd_sent && done_csr) cr_q <= rd_data_csr;
                S_POLL_E, S_POLL_W:
                    if (poll_done && poll_timeout && err_q == ERR_NONE) err_q <= ERR_TIMEOUT;
                S_CHK_E: if (!poll_ok[1] && err_q == ERR_NONE) err_q <= ERR_ERASE;
                S_WAIT_SRC: if (src_valid) word_q <= src_data;
                S_CHK_W: begin
                    if (!poll_ok[0]) begin
                        if (err_q == ERR_NONE) err_q <= ERR_WRITE;
                    end else begin
                        idx_q <= idx_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_update_sequencer.sv
// Directed bench for flash_update_sequencer with a small FlashControl model.
module tb_flash_update_sequencer;

    localparam int ADDR_W     = 17;
    localparam int CNT_W      = 17;
    localparam int POLL_LIMIT = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_sector = '0;
    logic [ADDR_W-1:0] cmd_base = '0;
    logic [CNT_W-1:0]  cmd_num = '0;
    logic              src_valid = 1'b0;
    logic              src_ready;
    logic [31:0]       src_data = '0;
    logic              busy, done, err;
    logic [2:0]        err_code;
    logic              start_rdsr, start_rdcr, start_wrcr, start_wrdata;
    logic [31:0]       wr_data_csr;
    logic [31:0]       rd_data_csr = '0;
    logic              done_csr = 1'b0;
    logic [23:0]       rw_addr_data;
    logic [31:0]       wr_data_data;
    logic              done_data = 1'b0;

    always #5 clk = ~clk;

    flash_update_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .POLL_LIMIT(POLL_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sector(cmd_sector),
        .cmd_base(cmd_base), .cmd_num(cmd_num),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .start_rdsr(start_rdsr), .start_rdcr(start_rdcr), .start_wrcr(start_wrcr),
        .wr_data_csr(wr_data_csr), .rd_data_csr(rd_data_csr), .done_csr(done_csr),
        .start_wrdata(start_wrdata), .rw_addr_data(rw_addr_data),
        .wr_data_data(wr_data_data), .done_data(done_data)
    );

    int checks = 0;
    int failures = 0;

    // Flash model configuration (written by the stimulus block only).
    int erase_busy = 10;
    bit e_ok = 1'b1;
    int fail_idx = 999;

    // Flash model state and logs (written by the model process only).
    logic [31:0] cr_m = 32'h5FFF_FFFF;
    int          busy_left = 0, w_since_erase = 0, pend = 0;
    bit          pend_is_csr = 1'b0;
    logic [31:0] pend_rd = '0;
    int          n_start = 0, n_rdsr = 0, n_wcr = 0, n_wr = 0, n_src = 0, proto_err = 0;
    logic [31:0] wcr_log [64];
    logic [23:0] wa_log  [64];
    logic [31:0] wd_log  [64];
    logic [31:0] sr_idle;
    int          n_starts_now;

    assign sr_idle = {27'd0, e_ok, ((w_since_erase - 1) != fail_idx), 3'd0};
    assign n_starts_now = int'(start_rdcr) + int'(start_rdsr) + int'(start_wrcr) + int'(start_wrdata);

    // FlashControl model: done pulse two cycles after each start; busy SR reads after erase/write.
    always @(posedge clk) begin
        if (!reset) begin
            done_csr  <= 1'b0;
            done_data <= 1'b0;
            pend      <= 0;
        end else begin
            done_csr  <= 1'b0;
            done_data <= 1'b0;
            if (pend > 0) pend <= pend - 1;
            if (pend == 1) begin
                done_csr    <= pend_is_csr;
                done_data   <= !pend_is_csr;
                rd_data_csr <= pend_rd;
            end
            if (src_ready) n_src <= n_src + 1;
            if (n_starts_now != 0) begin
                n_start     <= n_start + 1;
                pend        <= 2;
                pend_is_csr <= !start_wrdata;
                if (pend != 0 || done_csr || done_data || n_starts_now > 1)
                    proto_err <= proto_err + 1;
                if (start_rdcr) pend_rd <= cr_m;
                if (start_rdsr) begin
                    n_rdsr <= n_rdsr + 1;
                    if (busy_left > 0) begin
                        busy_left <= busy_left - 1;
                        pend_rd   <= 32'h1;
                    end else begin
                        pend_rd <= sr_idle;
                    end
                end
                if (start_wrcr) begin
                    cr_m <= wr_data_csr;
                    wcr_log[n_wcr % 64] <= wr_data_csr;
                    n_wcr <= n_wcr + 1;
                    if (wr_data_csr[22:20] != 3'd7) begin
                        busy_left     <= erase_busy;
                        w_since_erase <= 0;
                    end
                end
                if (start_wrdata) begin
                    wa_log[n_wr % 64] <= rw_addr_data;
                    wd_log[n_wr % 64] <= wr_data_data;
                    n_wr          <= n_wr + 1;
                    w_since_erase <= w_since_erase + 1;
                    busy_left     <= 2;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one command; returns at the negedge just after the accepting edge.
    task automatic send_cmd(input logic [2:0] sec, input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] num);
        bit got;
        got = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) chk("cmd_ready_wait", 32'd0, 32'd1);
        cmd_valid = 1'b1; cmd_sector = sec; cmd_base = base; cmd_num = num;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_sector = 3'd6; cmd_base = '1; cmd_num = '1;
    endtask

    task automatic wait_done(output logic e, output logic [2:0] code);
        bit got;
        got = 1'b0; e = 1'bx; code = 3'bx;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin got = 1'b1; e = err; code = err_code; break; end
            @(negedge clk);
        end
        if (!got) chk("done_wait", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic feed(input logic [31:0] w, input int gap);
        bit got;
        got = 1'b0;
        repeat (gap) @(negedge clk);
        src_valid = 1'b1; src_data = w;
        for (int i = 0; i < 1000; i++) begin
            #1;
            if (src_ready) begin got = 1'b1; @(negedge clk); break; end
            @(negedge clk);
        end
        src_valid = 1'b0; src_data = 32'hDEAD_BEEF;
        if (!got) chk("src_handshake_wait", 32'd0, 32'd1);
    endtask

    logic       e;
    logic [2:0] code;
    int s_wcr, s_wr, s_src, s_rdsr, s_start;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy_done_err", {busy, done, err}, 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_starts", {start_rdsr, start_rdcr, start_wrcr, start_wrdata, src_ready}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Sector 2, erase only, 10 busy SR reads
        s_wcr = n_wcr; s_wr = n_wr; s_rdsr = n_rdsr;
        send_cmd(3'd2, 17'h00000, 17'd0);
        wait_done(e, code);
        chk("s2_err", 32'(e), 32'd0);
        chk("s2_code", 32'(code), 32'd0);
        chk("s2_wcr_count", 32'(n_wcr - s_wcr), 32'd3);
        chk("s2_unprot", wcr_log[s_wcr % 64], 32'h5EFF_FFFF);
        chk("s2_erase", wcr_log[(s_wcr + 1) % 64], 32'h5EAF_FFFF);
        chk("s2_restore", wcr_log[(s_wcr + 2) % 64], 32'h5FFF_FFFF);
        chk("s2_rdsr_count", 32'(n_rdsr - s_rdsr), 32'd11);
        chk("s2_no_writes", 32'(n_wr - s_wr), 32'd0);

        // Sector 3, four words with source gaps
        erase_busy = 3;
        s_wcr = n_wcr; s_wr = n_wr; s_src = n_src;
        send_cmd(3'd3, 17'h08000, 17'd4);
        fork
            wait_done(e, code);
            begin
                feed(32'h0000_00A0, 0);
                feed(32'h0000_00A1, 2);
                feed(32'h0000_00A2, 0);
                feed(32'h0000_00A3, 3);
            end
        join
        chk("s3_err", 32'(e), 32'd0);
        chk("s3_wr_count", 32'(n_wr - s_wr), 32'd4);
        chk("s3_src_pulses", 32'(n_src - s_src), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("s3_addr", 32'(wa_log[(s_wr + i) % 64]), 32'h0000_8000 + 32'(i));
            chk("s3_data", wd_log[(s_wr + i) % 64], 32'h0000_00A0 + 32'(i));
        end
        chk("s3_unprot", wcr_log[s_wcr % 64], 32'h5DFF_FFFF);
        chk("s3_erase", wcr_log[(s_wcr + 1) % 64], 32'h5DBF_FFFF);
        chk("s3_restore", wcr_log[(s_wcr + 2) % 64], 32'h5FFF_FFFF);

        // Sector 5, address wrap at the top of the word space
        erase_busy = 2;
        s_wcr = n_wcr; s_wr = n_wr;
        send_cmd(3'd5, 17'h1FFFE, 17'd3);
        fork
            wait_done(e, code);
            begin
                feed(32'h1111_0000, 1);
                feed(32'h1111_0001, 1);
                feed(32'h1111_0002, 1);
            end
        join
        chk("wrap_err", 32'(e), 32'd0);
        chk("wrap_unprot", wcr_log[s_wcr % 64], 32'h57FF_FFFF);
        chk("wrap_addr0", 32'(wa_log[s_wr % 64]), 32'h0001_FFFE);
        chk("wrap_addr1", 32'(wa_log[(s_wr + 1) % 64]), 32'h0001_FFFF);
        chk("wrap_addr2", 32'(wa_log[(s_wr + 2) % 64]), 32'h0000_0000);

        // Illegal sectors 0 and 6
        s_start = n_start;
        send_cmd(3'd0, 17'h00010, 17'd2);
        chk("sec0_done", 32'(done), 32'd1);
        chk("sec0_err", {err, err_code}, {28'd0, 1'b1, 3'd1});
        send_cmd(3'd6, 17'h00010, 17'd2);
        chk("sec6_done", 32'(done), 32'd1);
        chk("sec6_err", {err, err_code}, {28'd0, 1'b1, 3'd1});
        repeat (5) @(negedge clk);
        chk("bad_sec_no_starts", 32'(n_start - s_start), 32'd0);

        // Erase failure: no words consumed, CR restored
        e_ok = 1'b0;
        s_wcr = n_wcr; s_wr = n_wr; s_src = n_src;
        src_valid = 1'b1; src_data = 32'h7777_7777;
        send_cmd(3'd1, 17'h00020, 17'd2);
        wait_done(e, code);
        src_valid = 1'b0;
        e_ok = 1'b1;
        chk("efail_err", {e, code}, {28'd0, 1'b1, 3'd2});
        chk("efail_no_writes", 32'(n_wr - s_wr), 32'd0);
        chk("efail_no_src", 32'(n_src - s_src), 32'd0);
        chk("efail_wcr_count", 32'(n_wcr - s_wcr), 32'd3);
        chk("efail_unprot", wcr_log[s_wcr % 64], 32'h5F7F_FFFF);
        chk("efail_erase", wcr_log[(s_wcr + 1) % 64], 32'h5F1F_FFFF);
        chk("efail_restore", wcr_log[(s_wcr + 2) % 64], 32'h5FFF_FFFF);

        // Write failure on the second word
        fail_idx = 1;
        s_wcr = n_wcr; s_wr = n_wr; s_src = n_src;
        src_valid = 1'b1; src_data = 32'h0000_0055;
        send_cmd(3'd3, 17'h00010, 17'd4);
        wait_done(e, code);
        src_valid = 1'b0;
        fail_idx = 999;
        chk("wfail_err", {e, code}, {28'd0, 1'b1, 3'd3});
        chk("wfail_writes", 32'(n_wr - s_wr), 32'd2);
        chk("wfail_src", 32'(n_src - s_src), 32'd2);
        chk("wfail_restore", wcr_log[(n_wcr - 1) % 64], 32'h5FFF_FFFF);

        // SR stuck busy: exactly POLL_LIMIT reads then timeout
        erase_busy = 1000;
        s_wcr = n_wcr; s_wr = n_wr; s_rdsr = n_rdsr;
        send_cmd(3'd4, 17'h00000, 17'd1);
        wait_done(e, code);
        erase_busy = 2;
        chk("tmo_err", {e, code}, {28'd0, 1'b1, 3'd4});
        chk("tmo_rdsr_count", 32'(n_rdsr - s_rdsr), 32'd16);
        chk("tmo_wcr_count", 32'(n_wcr - s_wcr), 32'd3);
        chk("tmo_unprot", wcr_log[s_wcr % 64], 32'h5BFF_FFFF);
        chk("tmo_restore", wcr_log[(s_wcr + 2) % 64], 32'h5FFF_FFFF);
        chk("tmo_no_writes", 32'(n_wr - s_wr), 32'd0);
        chk("protocol_violations", 32'(proto_err), 32'd0);

        // Reset asserted while polling a word write
        s_wr = n_wr;
        send_cmd(3'd2, 17'h00100, 17'd3);
        feed(32'h0000_00C0, 3);
        for (int i = 0; i < 200 && n_wr == s_wr; i++) @(negedge clk);
        s_rdsr = n_rdsr;
        for (int i = 0; i < 200 && n_rdsr == s_rdsr; i++) @(negedge clk);
        chk("rst_mid_reached_poll_w", 32'(n_rdsr > s_rdsr), 32'd1);
        src_valid = 1'b1;
        reset = 1'b0;
        #1;
        chk("rstm_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rstm_flags", {busy, done, err, src_ready}, 32'd0);
        chk("rstm_err_code", 32'(err_code), 32'd0);
        chk("rstm_starts", {start_rdsr, start_rdcr, start_wrcr, start_wrdata}, 32'd0);
        chk("rstm_addr", 32'(rw_addr_data), 32'd0);
        repeat (2) @(negedge clk);
        src_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rstm_cmd_ready_after", 32'(cmd_ready), 32'd1);
        chk("rstm_busy_after", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
